// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the 7-segment scan controller:
// FSM state encoding, the blank pattern and the active-low hex glyph table.
package sev_seg_pkg;

    typedef enum logic {S_BLANK, S_ON} scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g}; a 0 bit lights that segment.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/sev_seg_scan_ctrl_if.sv
// Application-to-display bundle: staged digit data in, board pin drives out.
// The application side is the master; the scan controller is the slave.
interface sev_seg_scan_ctrl_if #(
    parameter int N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   digit_en;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic                  load_pending;
    logic                  frame_done;
    logic [N_DIGITS-1:0]   anodes;
    logic [6:0]            segments;
    logic                  dp;

    modport master (
        output value, digit_en, dp_in, load,
        input  load_pending, frame_done, anodes, segments, dp
    );

    modport slave (
        input  value, digit_en, dp_in, load,
        output load_pending, frame_done, anodes, segments, dp
    );
endinterface

// File: rtl/hex_to_sev_seg.sv
// Combinational nibble to active-low segment decoder; one instance is
// shared by every digit through the scan multiplexer.
module hex_to_sev_seg
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);
    assign segments = SEG_TABLE[nibble];
endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment bank with
// inter-digit blanking and a frame-synchronous shadow register.
module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    sev_seg_scan_ctrl_if.slave  bus
);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    scan_state_t                 state;
    logic [CW-1:0]               cnt;
    logic [IW-1:0]               idx;

    logic [N_DIGITS-1:0][3:0]    val_stg, val_sh;
    logic [N_DIGITS-1:0]         en_stg, en_sh;
    logic [N_DIGITS-1:0]         dp_stg, dp_sh;
    logic                        load_pending;
    logic                        frame_done;

    logic [N_DIGITS-1:0]         anodes_q;
    logic [6:0]                  seg_q;
    logic                        dp_q;

    logic                        slot_end, blank_end, wrap;
    logic [6:0]                  seg_dec;
    logic [N_DIGITS-1:0]         an_lit;

    assign slot_end  = (cnt == SLOT_LAST);
    assign blank_end = (cnt == BLANK_LAST);
    assign wrap      = slot_end && (idx == IDX_LAST);

    hex_to_sev_seg u_dec (
        .nibble   (val_sh[idx]),
        .segments (seg_dec)
    );

    // NOTE: default every always_comb output first so no path leaves it unassigned and infers a latch.
    always_comb begin
        an_lit      = '1;
        an_lit[idx] = ~en_sh[idx];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_BLANK;
            cnt          <= '0;
            idx          <= '0;
            // NOTE: shadow and staging are reset, unlike a RAM, because a cleared en_sh keeps the display dark.
            val_stg      <= '0;
            en_stg       <= '0;
            dp_stg       <= '0;
            val_sh       <= '0;
            en_sh        <= '0;
            dp_sh        <= '0;
            load_pending <= 1'b0;
            frame_done   <= 1'b0;
            anodes_q     <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            frame_done <= 1'b0;

            if (bus.load) begin
                val_stg <= bus.value;
                en_stg  <= bus.digit_en;
                dp_stg  <= bus.dp_in;
            end

            // Commit only on the frame wrap; a load on that very edge bypasses staging.
            if (wrap) begin
                if (bus.load) begin
                    val_sh <= bus.value;
                    en_sh  <= bus.digit_en;
                    dp_sh  <= bus.dp_in;
                end else if (load_pending) begin
                    val_sh <= val_stg;
                    en_sh  <= en_stg;
                    dp_sh  <= dp_stg;
                end
                load_pending <= 1'b0;
            end else if (bus.load) begin
                load_pending <= 1'b1;
            end

            case (state)
                S_BLANK: begin
                    cnt <= cnt + 1'b1;
                    if (blank_end) begin
                        state    <= S_ON;
                        anodes_q <= an_lit;
                        seg_q    <= seg_dec;
                        dp_q     <= ~dp_sh[idx];
                    end
                end
                S_ON: begin
                    if (slot_end) begin
                        cnt        <= '0;
                        idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        state      <= S_BLANK;
                        anodes_q   <= '1;
                        seg_q      <= SEG_BLANK;
                        dp_q       <= 1'b1;
                        frame_done <= wrap;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.anodes       = anodes_q;
    assign bus.segments     = seg_q;
    assign bus.dp           = dp_q;
    assign bus.frame_done   = frame_done;
    assign bus.load_pending = load_pending;

endmodule
